// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter: FSM states, digit width,
// per-field last values and BCD digit-split helpers for constant limits.
package clock_pkg;

  localparam int BCD_W    = 4;
  localparam int SEC_LAST = 59;
  localparam int MIN_LAST = 59;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  function automatic logic [BCD_W-1:0] tens_of(input int v);
    return BCD_W'(v / 10);
  endfunction

  function automatic logic [BCD_W-1:0] ones_of(input int v);
    return BCD_W'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD counter wrapping to 00 after LAST_T:LAST_O. CARRY flags the
// enabled increment that performs the wrap.
module bcd_pair_cnt
  import clock_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [BCD_W-1:0] LAST_T,
  input  logic [BCD_W-1:0] LAST_O,
  output logic [BCD_W-1:0] T,
  output logic [BCD_W-1:0] O,
  output logic             CARRY
);

  logic [BCD_W-1:0] t_reg;
  logic [BCD_W-1:0] o_reg;
  logic             at_last;
  logic             illegal;

  assign at_last = (t_reg == LAST_T) && (o_reg == LAST_O);
  // Out-of-range digits (upset only) are folded into the wrap path so the
  // field self-corrects to 00 on its next increment.
  assign illegal = (o_reg > BCD_W'(9)) || (t_reg > LAST_T) ||
                   ((t_reg == LAST_T) && (o_reg > LAST_O));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      t_reg <= '0;
      o_reg <= '0;
    end else if (CLR) begin
      t_reg <= '0;
      o_reg <= '0;
    end else if (EN) begin
      if (at_last || illegal) begin
        t_reg <= '0;
        o_reg <= '0;
      end else if (o_reg == BCD_W'(9)) begin
        t_reg <= t_reg + BCD_W'(1);
        o_reg <= '0;
      end else begin
        o_reg <= o_reg + BCD_W'(1);
      end
    end
  end

  assign T     = t_reg;
  assign O     = o_reg;
  assign CARRY = EN && at_last;

endmodule

// File: rtl/clock_time_cnt.sv
// HH:MM:SS BCD time-of-day counter with hour/minute set mode and a one-cycle
// day-carry pulse on midnight rollover.
module clock_time_cnt
  import clock_pkg::*;
#(
  parameter int MAX_HOUR = 23
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN1HZ,
  input  logic             MODE_BTN,
  input  logic             INC_BTN,
  output logic [BCD_W-1:0] HOUR_T,
  output logic [BCD_W-1:0] HOUR_O,
  output logic [BCD_W-1:0] MIN_T,
  output logic [BCD_W-1:0] MIN_O,
  output logic [BCD_W-1:0] SEC_T,
  output logic [BCD_W-1:0] SEC_O,
  output logic [1:0]       SETMODE,
  output logic             CARRY_DAY
);

  localparam logic [BCD_W-1:0] SEC_LAST_T  = tens_of(SEC_LAST);
  localparam logic [BCD_W-1:0] SEC_LAST_O  = ones_of(SEC_LAST);
  localparam logic [BCD_W-1:0] MIN_LAST_T  = tens_of(MIN_LAST);
  localparam logic [BCD_W-1:0] MIN_LAST_O  = ones_of(MIN_LAST);
  localparam logic [BCD_W-1:0] HOUR_LAST_T = tens_of(MAX_HOUR);
  localparam logic [BCD_W-1:0] HOUR_LAST_O = ones_of(MAX_HOUR);

  state_t state_reg;
  logic   carry_day_reg;
  logic   run;
  logic   inc_ok;
  logic   sec_en, min_en, hour_en, sec_clr;
  logic   sec_carry, min_carry, hour_carry;

  assign run    = (state_reg == ST_RUN);
  // A simultaneous mode press swallows the increment.
  assign inc_ok = INC_BTN && !MODE_BTN;

  assign sec_en  = run && EN1HZ;
  assign min_en  = (run && sec_carry) ||
                   ((state_reg == ST_SET_MIN) && inc_ok);
  assign hour_en = (run && sec_carry && min_carry) ||
                   ((state_reg == ST_SET_HOUR) && inc_ok);
  assign sec_clr = (state_reg == ST_SET_MIN) && MODE_BTN;

  bcd_pair_cnt u_sec (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (sec_en),
    .CLR    (sec_clr),
    .LAST_T (SEC_LAST_T),
    .LAST_O (SEC_LAST_O),
    .T      (SEC_T),
    .O      (SEC_O),
    .CARRY  (sec_carry)
  );

  bcd_pair_cnt u_min (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (min_en),
    .CLR    (1'b0),
    .LAST_T (MIN_LAST_T),
    .LAST_O (MIN_LAST_O),
    .T      (MIN_T),
    .O      (MIN_O),
    .CARRY  (min_carry)
  );

  bcd_pair_cnt u_hour (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (hour_en),
    .CLR    (1'b0),
    .LAST_T (HOUR_LAST_T),
    .LAST_O (HOUR_LAST_O),
    .T      (HOUR_T),
    .O      (HOUR_O),
    .CARRY  (hour_carry)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg     <= ST_RUN;
      carry_day_reg <= 1'b0;
    end else begin
      // Set-mode hour wraps also raise hour_carry; only a running rollover counts.
      carry_day_reg <= run && hour_carry;
      case (state_reg)
        ST_RUN:      if (MODE_BTN) state_reg <= ST_SET_HOUR;
        ST_SET_HOUR: if (MODE_BTN) state_reg <= ST_SET_MIN;
        ST_SET_MIN:  if (MODE_BTN) state_reg <= ST_RUN;
        default:     state_reg <= ST_RUN;
      endcase
    end
  end

  assign SETMODE   = state_reg;
  assign CARRY_DAY = carry_day_reg;

endmodule

// File: tb/tb_clock_time_cnt.sv
// Self-checking bench for clock_time_cnt against a seconds-of-day reference model.
module tb_clock_time_cnt;

  localparam int MAXH = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en1hz = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
  logic [1:0] setmode;
  logic       carry_day;
  logic [26:0] obs;

  int   checks = 0;
  int   passes = 0;
  int   m_h = 0, m_m = 0, m_s = 0, m_mode = 0;
  logic m_carry = 1'b0;

  clock_time_cnt #(.MAX_HOUR(MAXH)) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN1HZ     (en1hz),
    .MODE_BTN  (mode_btn),
    .INC_BTN   (inc_btn),
    .HOUR_T    (hour_t),
    .HOUR_O    (hour_o),
    .MIN_T     (min_t),
    .MIN_O     (min_o),
    .SEC_T     (sec_t),
    .SEC_O     (sec_o),
    .SETMODE   (setmode),
    .CARRY_DAY (carry_day)
  );

  always #5 clk = ~clk;

  assign obs = {setmode, carry_day, hour_t, hour_o, min_t, min_o, sec_t, sec_o};

  function automatic logic [26:0] exp_vec();
    return {2'(m_mode), m_carry, 4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10),
            4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
  endfunction

  // Drive one cycle of inputs and advance the reference model by one edge.
  task automatic drive(input bit en, input bit md, input bit inc);
    int tod;
    en1hz = en; mode_btn = md; inc_btn = inc;
    @(posedge clk);
    if (!rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_carry = 1'b0;
    end else begin
      m_carry = 1'b0;
      if (m_mode == 0) begin
        if (en) begin
          tod = m_h * 3600 + m_m * 60 + m_s + 1;
          if (tod == (MAXH + 1) * 3600) begin
            tod = 0;
            m_carry = 1'b1;
          end
          m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
        end
      end else if (!md && inc) begin
        if (m_mode == 1) m_h = (m_h + 1) % (MAXH + 1);
        else             m_m = (m_m + 1) % 60;
      end
      if (md) begin
        if (m_mode == 2) m_s = 0;
        m_mode = (m_mode + 1) % 3;
      end
    end
    #1;
    en1hz = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 1);
    drive(1, 0, 1);
    checks++;
    if (obs !== 27'd0) $display("FAIL reset got=%h exp=%h", obs, 27'd0);
    else passes++;
    rst = 1'b1;
    checks++;
    if (obs !== exp_vec()) $display("FAIL reset_model got=%h exp=%h", obs, exp_vec());
    else passes++;
  endtask

  task automatic test_count();
    for (int i = 1; i <= 3600; i++) begin
      drive(1, 0, 0);
      checks++;
      if (obs !== exp_vec()) $display("FAIL count_%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
      if (i == 59 || i == 60 || i == 3600) begin
        logic [26:0] want;
        want = (i == 59) ? 27'h0000059 : (i == 60) ? 27'h0000100 : 27'h0010000;
        checks++;
        if (obs !== want) $display("FAIL count_const_%0d got=%h exp=%h", i, obs, want);
        else passes++;
      end
    end
  endtask

  task automatic test_set();
    rst = 1'b0; drive(0, 0, 0); rst = 1'b1;
    drive(0, 1, 0);
    for (int i = 0; i < 25; i++) drive(0, 0, 1);
    checks++;
    if (obs !== 27'h2010000) $display("FAIL set_hour got=%h exp=%h", obs, 27'h2010000);
    else passes++;
    drive(0, 1, 0);
    for (int i = 0; i < 61; i++) drive(0, 0, 1);
    checks++;
    if (obs !== 27'h4010100) $display("FAIL set_min got=%h exp=%h", obs, 27'h4010100);
    else passes++;
    for (int i = 0; i < 5; i++) drive(1, 0, 0);
    checks++;
    if (obs !== exp_vec()) $display("FAIL set_frozen got=%h exp=%h", obs, exp_vec());
    else passes++;
    drive(0, 1, 0);
    checks++;
    if (obs !== 27'h0010100) $display("FAIL set_exit got=%h exp=%h", obs, 27'h0010100);
    else passes++;
  endtask

  task automatic test_midnight();
    rst = 1'b0; drive(0, 0, 0); rst = 1'b1;
    drive(0, 1, 0);
    for (int i = 0; i < MAXH; i++) drive(0, 0, 1);
    drive(0, 1, 0);
    for (int i = 0; i < 59; i++) drive(0, 0, 1);
    drive(0, 1, 0);
    for (int i = 0; i < 59; i++) drive(1, 0, 0);
    checks++;
    if (obs !== 27'h0235959) $display("FAIL midnight_pre got=%h exp=%h", obs, 27'h0235959);
    else passes++;
    drive(1, 0, 0);
    checks++;
    if (obs !== 27'h1000000) $display("FAIL midnight_roll got=%h exp=%h", obs, 27'h1000000);
    else passes++;
    drive(0, 0, 0);
    checks++;
    if (obs !== exp_vec() || carry_day !== 1'b0)
      $display("FAIL midnight_pulse_end got=%h exp=%h", obs, exp_vec());
    else passes++;
  endtask

  task automatic test_back_to_back();
    rst = 1'b0; drive(0, 0, 0); rst = 1'b1;
    for (int i = 0; i < 10; i++) drive(1, 0, 0);
    drive(1, 1, 0);
    checks++;
    if (obs !== 27'h2000011) $display("FAIL tick_mode got=%h exp=%h", obs, 27'h2000011);
    else passes++;
    drive(0, 1, 1);
    checks++;
    if (obs !== 27'h4000011) $display("FAIL mode_inc got=%h exp=%h", obs, 27'h4000011);
    else passes++;
  endtask

  task automatic test_reset_midset();
    rst = 1'b0; drive(0, 0, 0); rst = 1'b1;
    for (int i = 0; i < 56; i++) drive(1, 0, 0);
    drive(0, 1, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 1);
    drive(0, 1, 0);
    for (int i = 0; i < 34; i++) drive(0, 0, 1);
    checks++;
    if (obs !== 27'h4123456) $display("FAIL midset_pre got=%h exp=%h", obs, 27'h4123456);
    else passes++;
    rst = 1'b0; drive(1, 1, 1); rst = 1'b1;
    checks++;
    if (obs !== 27'd0) $display("FAIL midset_reset got=%h exp=%h", obs, 27'd0);
    else passes++;
    drive(0, 0, 1);
    checks++;
    if (obs !== 27'd0) $display("FAIL run_inc got=%h exp=%h", obs, 27'd0);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit en, md, inc;
      en  = ($urandom_range(1) == 1);
      md  = ($urandom_range(15) == 0);
      inc = ($urandom_range(2) == 0);
      rst = ($urandom_range(499) != 0);
      drive(en, md, inc);
      rst = 1'b1;
      checks++;
      if (obs !== exp_vec()) $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_set();
    test_midnight();
    test_back_to_back();
    test_reset_midset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
